seq_divider_n_bit: RTL and testbench
====================================

Name: seq_divider_n_bit

Overview:
- Multi-cycle N-bit integer divider for the ALU datapath.
- Computes quotient and remainder of dividend/divisor, one restoring subtract-shift step per clock.
- Takes the same `sign` control as the ALU adder: 0 = unsigned, 1 = two's-complement signed.
- Fills the inverse-arithmetic slot next to the adder; the ALU control FSM drives it with a start/done handshake.

Parameters:
- N, 8, operand/result width in bits (N >= 2)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request a division; sampled only in IDLE
- sign  input  1  0 = unsigned, 1 = signed; captured with start
- dividend  input  N  numerator; captured with start
- divisor  input  N  denominator; captured with start
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when results become valid
- quotient  output  N  result quotient; held until the next accepted start
- remainder  output  N  result remainder; held until the next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with the results

Behaviour:
- Reset: synchronous, active-high, wins over everything, including mid-operation.
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared.
- States: IDLE, CALC, FIX.
- IDLE, start=1 in cycle t: capture sign, operand signs and operand magnitudes.
  - Magnitude = two's-complement negate when sign=1 and MSB=1; otherwise the raw value.
  - Magnitude is held as N-bit unsigned, so -2^(N-1) gives 2^(N-1).
  - Clear the N+1-bit partial remainder, load the quotient shift register with |dividend|.
  - If divisor==0: go to FIX directly.
  - Otherwise: set step counter to N, go to CALC.
  - busy=1 from cycle t+1.
- CALC, one restoring step per cycle:
  - Shift {partial remainder, quotient register} left by 1.
  - Trial = partial remainder - {0,|divisor|}.
  - If trial is non-negative (no borrow): partial remainder = trial, quotient LSB = 1; else quotient LSB = 0.
  - Decrement the counter; after N steps (cycles t+1..t+N) go to FIX.
- FIX, one cycle (t+N+1):
  - Signed mode: negate the quotient if the dividend and divisor signs differ; negate the remainder if the dividend was negative.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Register the outputs, pulse done=1 for exactly this cycle, drop busy, return to IDLE.
- Latency: done at cycle t+N+1 for a non-zero divisor; at t+1 for divisor==0.
- Divide by zero: quotient = all ones, remainder = dividend (raw), div_by_zero=1.
- Signed overflow (-2^(N-1) / -1): quotient wraps to -2^(N-1), remainder = 0, no extra flag.
- div_by_zero clears on the next accepted start.
- Back-to-back: start may be asserted in the IDLE cycle right after done; minimum issue interval is N+2 cycles.
- start while busy: ignored, with no effect on the operation in flight. Operand changes while busy are also ignored.
- Outputs are registered only; no combinational path from any input to any output.

Decomposition:
- Shared package seq_div_pkg holds:
  - State enum (IDLE, CALC, FIX).
  - Counter width constant = $clog2(N+1).
  - Negate helper function.
  - DIV0_QUOTIENT constant (all ones).
- One natural sub-module: div_sub_stage.
  - Combinational N+1-bit trial subtract returning the difference and a borrow flag.
  - Instantiated once inside the CALC datapath.
- The FSM, counter and shift registers stay in seq_divider_n_bit.

Test Plan (N=8, start at cycle t):
- Unsigned: sign=0, 200/7 -> done at t+9, quotient=28 (0x1C), remainder=4, div_by_zero=0; busy high t+1..t+8.
- Signed: sign=1, -100 (0x9C) / 7 -> quotient=-14 (0xF2), remainder=-2 (0xFE).
- Signed overflow: sign=1, 0x80 / 0xFF -> quotient=0x80, remainder=0x00, done at t+9.
- Divide by zero: sign=0, 55/0 -> done at t+1, quotient=0xFF, remainder=55, div_by_zero=1; the next start with 9/3 clears div_by_zero and gives quotient=3, remainder=0.
- Busy/restart: start 100/9, pulse start with 1/1 at t+4 -> ignored, result quotient=11, remainder=1 at t+9; start again at t+10 -> accepted.
- Reset mid-op: start 250/3, assert rst at t+5 -> next cycle busy=0, done=0, outputs 0; no done pulse follows; a new start 250/3 gives quotient=83, remainder=1 at the expected latency.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential divider.
// - state_e        : FSM states (IDLE, CALC, FIX)
// - cnt_w()        : step-counter width for an N-bit divide, $clog2(N+1)
// - neg64()        : two's-complement negate on a 64-bit carrier; callers
//                    cast the result to their own width (supports N <= 64)
// - DIV0_QUOTIENT  : all-ones quotient returned on divide by zero; callers
//                    slice it to their own width
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] DIV0_QUOTIENT = '1;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [MAX_W-1:0] neg64(input logic [MAX_W-1:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational trial subtract for one restoring-division step.
// Ports:
//   minuend    in  W  shifted partial remainder
//   subtrahend in  W  zero-extended divisor magnitude
//   diff       out W  minuend - subtrahend (modulo 2^W)
//   borrow     out 1  1 when subtrahend > minuend (trial is negative)
module div_sub_stage #(
  parameter int W = 9
) (
  input  logic [W-1:0] minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // One extra bit catches the borrow out of the top position.
  logic [W:0] wide;

  assign wide   = {1'b0, minuend} - {1'b0, subtrahend};
  assign diff   = wide[W-1:0];
  assign borrow = wide[W];

endmodule

// File: rtl/seq_divider_n_bit.sv
// Multi-cycle N-bit restoring divider (unsigned or two's-complement signed).
// One subtract-shift step per clock; done pulses N+1 cycles after an accepted
// start (1 cycle for a zero divisor). Results are held until the next start.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request a division (sampled only in IDLE)
//   sign          0 = unsigned, 1 = signed (captured with start)
//   dividend      numerator (captured with start)
//   divisor       denominator (captured with start)
//   busy          high while the iterative steps run
//   done          one-cycle pulse when results are valid
//   quotient      result quotient
//   remainder     result remainder (takes the dividend's sign)
//   div_by_zero   set with done when the divisor was zero
module seq_divider_n_bit
  import seq_div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sign,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_w(N);

  function automatic logic [N-1:0] neg_n(input logic [N-1:0] x);
    return N'(neg64(64'(x)));
  endfunction

  function automatic logic [N-1:0] magnitude(input logic s, input logic [N-1:0] x);
    return (s && x[N-1]) ? neg_n(x) : x;
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     rem_q, rem_d;       // partial remainder
  logic [N-1:0]   quo_q, quo_d;       // quotient shift register (starts as |dividend|)
  logic [N-1:0]   dvs_q, dvs_d;       // |divisor|
  logic           dvd_neg_q, dvd_neg_d;
  logic           dvs_neg_q, dvs_neg_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     shifted;
  logic [N:0]     trial;
  logic           borrow;
  logic [N:0]     rem_step;
  logic [N-1:0]   quo_step;

  // Partial remainder stays below |divisor| so its top bit is always clear
  // before the shift; the shift pulls in the next dividend bit.
  assign shifted = (rem_q << 1) | (N+1)'(quo_q[N-1]);

  div_sub_stage #(.W(N+1)) u_sub (
    .minuend   (shifted),
    .subtrahend({1'b0, dvs_q}),
    .diff      (trial),
    .borrow    (borrow)
  );

  assign rem_step = borrow ? shifted : trial;
  assign quo_step = {quo_q[N-2:0], ~borrow};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_neg_d   = dvd_neg_q;
    dvs_neg_d   = dvs_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_neg_d = sign & dividend[N-1];
          dvs_neg_d = sign & divisor[N-1];
          rem_d     = '0;
          quo_d     = magnitude(sign, dividend);
          dvs_d     = magnitude(sign, divisor);
          dbz_d     = 1'b0;
          if (divisor == '0) begin
            // Zero divisor skips the iteration; results are known now.
            quotient_d  = N'(DIV0_QUOTIENT);
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = FIX;
          end else begin
            cnt_d   = CW'(N);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Sign correction applied on the final step so results are
          // registered and valid during the FIX (done) cycle.
          quotient_d  = (dvd_neg_q ^ dvs_neg_q) ? neg_n(quo_step) : quo_step;
          remainder_d = dvd_neg_q ? neg_n(rem_step[N-1:0]) : rem_step[N-1:0];
          state_d     = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_neg_q   <= dvd_neg_d;
      dvs_neg_q   <= dvs_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == FIX);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_n_bit.sv
module tb_seq_divider_n_bit;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sign = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider_n_bit #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sign       (sign),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic: plain integer division, which truncates toward zero
  // and gives the remainder the dividend's sign.
  function automatic void model_div(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic z);
    int sa, sb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
      if (s) begin
        sa = int'($signed(a));
        sb = int'($signed(b));
        q  = N'(sa / sb);
        r  = N'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Transaction-level model: cycles left until the done pulse, plus results.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [N-1:0] m_q = '0, m_r = '0;
  logic         m_z = 1'b0;
  logic [N-1:0] p_q, p_r;
  logic         p_z;

  always @(posedge clk) begin
    logic prev_done;
    prev_done = m_done;
    m_done    = 1'b0;
    if (rst) begin
      m_left = 0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z;
      end
    end else if (!prev_done && start) begin
      model_div(sign, dividend, divisor, p_q, p_r, p_z);
      if (p_z) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = 1'b1;
      end else begin
        m_left = N;
        m_z    = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 32'(busy), 32'(m_left > 0));
    check("cyc_done", 32'(done), 32'(m_done));
    check("cyc_quotient", 32'(quotient), 32'(m_q));
    check("cyc_remainder", 32'(remainder), 32'(m_r));
    check("cyc_div_by_zero", 32'(div_by_zero), 32'(m_z));
  end

  // Drives start for one cycle; returns in cycle t+1.
  task automatic issue(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
    @(posedge clk); #1;
    start = 1'b1; sign = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; 'from' is the current cycle offset from t.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input int lat, input int elat,
                               input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_done"}, 32'(done), 32'(1));
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(ez));
  endtask

  task automatic run_op(input string tag, input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int elat, input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
    int lat;
    issue(s, a, b);
    wait_done(1, lat);
    expect_result(tag, lat, elat, eq, er, ez);
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_quotient", 32'(quotient), 32'(0));
    check("reset_remainder", 32'(remainder), 32'(0));
    check("reset_dbz", 32'(div_by_zero), 32'(0));
    rst = 1'b0;

    // Unsigned 200/7, with busy across t+1..t+8.
    issue(1'b0, 8'd200, 8'd7);
    for (int k = 1; k <= 8; k++) begin
      check("u200_7_busy", 32'(busy), 32'(1));
      @(posedge clk); #1;
    end
    check("u200_7_busy_drop", 32'(busy), 32'(0));
    expect_result("u200_7", 9, 9, 8'h1C, 8'd4, 1'b0);

    run_op("s_m100_7", 1'b1, 8'h9C, 8'd7, 9, 8'hF2, 8'hFE, 1'b0);
    run_op("s_100_m7", 1'b1, 8'd100, 8'hF9, 9, 8'hF2, 8'h02, 1'b0);
    run_op("s_ovf", 1'b1, 8'h80, 8'hFF, 9, 8'h80, 8'h00, 1'b0);
    run_op("s_m128_3", 1'b1, 8'h80, 8'd3, 9, 8'hD6, 8'hFE, 1'b0);
    run_op("u255_1", 1'b0, 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
    run_op("u7_200", 1'b0, 8'd7, 8'd200, 9, 8'd0, 8'd7, 1'b0);
    run_op("u_div0", 1'b0, 8'd55, 8'd0, 1, 8'hFF, 8'd55, 1'b1);
    run_op("u9_3", 1'b0, 8'd9, 8'd3, 9, 8'd3, 8'd0, 1'b0);

    // Start and operand changes while busy must be ignored.
    issue(1'b0, 8'd100, 8'd9);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 8'd1; divisor = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(5, lat);
    expect_result("busy_100_9", lat, 9, 8'd11, 8'd1, 1'b0);
    run_op("restart_1_1", 1'b0, 8'd1, 8'd1, 9, 8'd1, 8'd0, 1'b0);

    // Reset in the middle of an operation.
    issue(1'b0, 8'd250, 8'd3);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_busy", 32'(busy), 32'(0));
    check("rstmid_done", 32'(done), 32'(0));
    check("rstmid_quotient", 32'(quotient), 32'(0));
    check("rstmid_remainder", 32'(remainder), 32'(0));
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("rstmid_no_done", 32'(done), 32'(0));
    end
    run_op("after_rst_250_3", 1'b0, 8'd250, 8'd3, 9, 8'd83, 8'd1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
